// File: rtl/serial_parity_checker.sv
// -----------------------------------------------------------------------------
// serial_parity_checker
//
// Checks one serial frame at a time. The frame is FRAME_LEN data bits
// followed by one parity bit. Each accepted data bit is XOR-folded into a
// running parity accumulator. The trailing parity bit is then compared against
// (accumulator ^ odd_mode), using the odd_mode value latched when the frame
// started.
//
// Optional feature (macro PARITY_ERR_COUNT_EN):
//   Adds err_count, a saturating 8-bit count of frames that finished with a
//   parity error. Only rst_n clears it.
//
// Parameters:
//   FRAME_LEN  data bits per frame, not counting the parity bit
//              (legal range 1 .. 2**CNT_W-1)
//   CNT_W      width of the data-bit counter and of bit_cnt
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a new frame; only looked at in IDLE
//   bit_in      serial data bit or parity bit
//   bit_valid   bit_in is valid this cycle; when low the frame stalls
//   odd_mode    0 = even parity, 1 = odd parity; latched on start
//   busy        high from the cycle after start is accepted until done
//   done        one-cycle pulse after the parity bit has been checked
//   parity_out  registered XOR of the data bits accepted so far;
//               held after done
//   parity_err  parity bit did not match; held until the next start
//   bit_cnt     number of data bits accepted in the current frame
//   err_count   (PARITY_ERR_COUNT_EN only) saturating errored-frame count
//   fsm_state   debug view of the FSM state (0 IDLE, 1 DATA, 2 PARITY)
//
// Handshake: a bit is consumed on every rising edge where bit_valid is high
// while the FSM is in DATA or PARITY. There is no back-pressure; the
// upstream side simply holds bit_valid low to stall.
// -----------------------------------------------------------------------------
module serial_parity_checker #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             odd_mode,
  output logic             busy,
  output logic             done,
  output logic             parity_out,
  output logic             parity_err,
  output logic [CNT_W-1:0] bit_cnt,
`ifdef PARITY_ERR_COUNT_EN
  output logic [7:0]       err_count,
`endif
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2
  } state_t;

  // Counter value just before the last data bit is accepted.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_n;
  logic             acc, acc_n;
  logic             mode, mode_n;
  logic [CNT_W-1:0] cnt_n;
  logic             busy_n, done_n, err_n;
  logic             frame_err;  // an errored frame completes on this edge

  assign parity_out = acc;
  assign fsm_state  = state;

  // Next-state and next-output logic
  always_comb begin
    state_n   = state;
    acc_n     = acc;
    mode_n    = mode;
    cnt_n     = bit_cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    err_n     = parity_err;
    frame_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_DATA;
          acc_n   = 1'b0;
          cnt_n   = '0;
          mode_n  = odd_mode;
          err_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      S_DATA: begin
        if (bit_valid) begin
          acc_n = acc ^ bit_in;
          cnt_n = bit_cnt + 1'b1;
          // The counter stops at FRAME_LEN because the FSM leaves DATA here.
          if (bit_cnt == LAST_IDX) begin
            state_n = S_PARITY;
          end
        end
      end
      S_PARITY: begin
        if (bit_valid) begin
          // Expected parity bit is acc ^ mode, so the bit is wrong when
          // bit_in ^ acc ^ mode is 1.
          err_n     = bit_in ^ acc ^ mode;
          frame_err = bit_in ^ acc ^ mode;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= 1'b0;
      mode       <= 1'b0;
      bit_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      mode       <= mode_n;
      bit_cnt    <= cnt_n;
      busy       <= busy_n;
      done       <= done_n;
      parity_err <= err_n;
    end
  end

`ifdef PARITY_ERR_COUNT_EN
  // Saturating errored-frame counter. It updates on the same edge that
  // raises done, so the new count is visible alongside the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (frame_err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// -----------------------------------------------------------------------------
// tb_serial_parity_checker
//
// Directed and random frames for serial_parity_checker. Inputs are driven
// and outputs are sampled just after the falling clock edge. Expected results
// come from a frame-level model: parity is the number of ones modulo 2, and
// the latency is the number of cycles the frame should take.
// -----------------------------------------------------------------------------
module tb_serial_parity_checker;

  localparam int FL = 8;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, bit_in, bit_valid, odd_mode;
  logic          busy, done, parity_out, parity_err;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    fsm_state;
`ifdef PARITY_ERR_COUNT_EN
  logic [7:0]    err_count;
  int            exp_ecnt;
`endif

  serial_parity_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .odd_mode   (odd_mode),
    .busy       (busy),
    .done       (done),
    .parity_out (parity_out),
    .parity_err (parity_err),
    .bit_cnt    (bit_cnt),
`ifdef PARITY_ERR_COUNT_EN
    .err_count  (err_count),
`endif
    .fsm_state  (fsm_state)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ones_parity(input logic [FL-1:0] data);
    int ones = 0;
    for (int i = 0; i < FL; i++) ones += int'(data[i]);
    return ones % 2;
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge. Raises start, sends data[0] first, and returns
  // at the falling edge where done is expected.
  task automatic send_frame(input logic odd, input logic [FL-1:0] data, input logic pbit,
                            input int stall_at, input int stall_n, input int pstall_n,
                            input int mid_start_at);
    int cyc;
    int exp_par;
    int exp_err;
    exp_par = ones_parity(data);
    exp_err = (int'(pbit) != (exp_par ^ int'(odd))) ? 1 : 0;
    start = 1'b1; odd_mode = odd; bit_valid = 1'b0; bit_in = 1'($urandom);
    @(negedge clk);
    cyc = 1;
    start = 1'b0; odd_mode = 1'($urandom);
    chk("busy_after_start", busy, 1);
    chk("err_clr_after_start", parity_err, 0);
    chk("cnt_clr_after_start", bit_cnt, 0);
    chk("par_clr_after_start", parity_out, 0);
    for (int i = 0; i < FL; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          bit_valid = 1'b0; bit_in = 1'($urandom); start = 1'b0;
          @(negedge clk); cyc++;
          chk("cnt_hold_stall", bit_cnt, i);
        end
      end
      start = (i == mid_start_at);
      if (start) odd_mode = ~odd;
      bit_valid = 1'b1; bit_in = data[i];
      @(negedge clk); cyc++;
      chk("no_done_in_data", done, 0);
    end
    start = 1'b0;
    chk("cnt_full", bit_cnt, FL);
    for (int s = 0; s < pstall_n; s++) begin
      bit_valid = 1'b0; bit_in = 1'($urandom);
      @(negedge clk); cyc++;
      chk("no_done_par_stall", done, 0);
      chk("busy_par_stall", busy, 1);
    end
    bit_valid = 1'b1; bit_in = pbit;
    @(negedge clk); cyc++;
    bit_valid = 1'b0;
    chk("done_pulse", done, 1);
    chk("latency", cyc, FL + 2 + stall_n + pstall_n);
    chk("busy_low_at_done", busy, 0);
    chk("parity_out", parity_out, exp_par);
    chk("parity_err", parity_err, exp_err);
    chk("bit_cnt_done", bit_cnt, FL);
`ifdef PARITY_ERR_COUNT_EN
    if (exp_err == 1 && exp_ecnt < 255) exp_ecnt++;
    chk("err_count", err_count, exp_ecnt);
`endif
  endtask

  // Idle cycles after a frame: done drops and the results stay put.
  task automatic idle_hold(input int n, input int exp_par, input int exp_err);
    for (int k = 0; k < n; k++) begin
      start = 1'b0; bit_valid = 1'($urandom); bit_in = 1'($urandom);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("hold_par", parity_out, exp_par);
      chk("hold_err", parity_err, exp_err);
      chk("hold_cnt", bit_cnt, FL);
    end
    bit_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FL-1:0] d_even;
    logic [FL-1:0] d_odd;
    logic [FL-1:0] rd;
    logic          rodd, rpbit;
    d_even = 8'b0100_1101;  // 1,0,1,1,0,0,1,0 sent LSB first
    d_odd  = 8'b0000_0111;  // 1,1,1,0,0,0,0,0
    start = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; odd_mode = 1'b0;
`ifdef PARITY_ERR_COUNT_EN
    exp_ecnt = 0;
`endif
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_par", parity_out, 0);
    chk("rst_err", parity_err, 0);
    chk("rst_cnt", bit_cnt, 0);
`ifdef PARITY_ERR_COUNT_EN
    chk("rst_ecnt", err_count, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Even parity: correct parity bit, then a wrong one.
    send_frame(1'b0, d_even, 1'b0, -1, 0, 0, -1);
    idle_hold(2, 0, 0);
    send_frame(1'b0, d_even, 1'b1, -1, 0, 0, -1);
    idle_hold(3, 0, 1);

    // Odd parity.
    send_frame(1'b1, d_odd, 1'b0, -1, 0, 0, -1);
    idle_hold(1, 1, 0);
    send_frame(1'b1, d_odd, 1'b1, -1, 0, 0, -1);
    idle_hold(1, 1, 1);

    // Stalls: 3 cycles after data bit 4 and 2 cycles in PARITY.
    send_frame(1'b0, d_even, 1'b0, 4, 3, 2, -1);
    idle_hold(1, 0, 0);

    // start pulsed during data bit 3 must be ignored.
    send_frame(1'b0, d_even, 1'b1, -1, 0, 0, 2);
    idle_hold(1, 0, 1);

    // Back-to-back: an errored frame, then start in its done cycle.
    send_frame(1'b1, d_even, 1'b0, -1, 0, 0, -1);
    send_frame(1'b0, d_odd, 1'b1, -1, 0, 0, -1);
    idle_hold(1, 1, 0);

    // Reset after 5 data bits: asynchronous clear and no done pulse.
    start = 1'b1; odd_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk);
    end
    chk("mid_cnt5", bit_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_par", parity_out, 0);
    chk("arst_err", parity_err, 0);
    chk("arst_cnt", bit_cnt, 0);
`ifdef PARITY_ERR_COUNT_EN
    exp_ecnt = 0;
    chk("arst_ecnt", err_count, 0);
`endif
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("arst_no_done", done, 0);
    end
    rst_n = 1'b1; bit_valid = 1'b0;
    @(negedge clk);
    send_frame(1'b0, d_even, 1'b1, -1, 0, 0, -1);
    idle_hold(1, 0, 1);

    // Random frames with random stalls and gaps.
    for (int f = 0; f < 24; f++) begin
      rd    = FL'($urandom);
      rodd  = 1'($urandom);
      rpbit = 1'($urandom);
      send_frame(rodd, rd, rpbit, int'($urandom_range(0, FL)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FL - 1)) : -1);
      if ($urandom_range(0, 2) != 0)
        idle_hold(int'($urandom_range(1, 3)), ones_parity(rd),
                  (int'(rpbit) != (ones_parity(rd) ^ int'(rodd))) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
